// File: rtl/id_ex_pkg.sv
// Shared widths for the ID/EX pipeline register: default field widths and
// the packed control-bundle width helper.
package id_ex_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefRegW   = 5;
  localparam int unsigned DefAluOpW = 2;
  localparam int unsigned DefMemW   = 3;
  localparam int unsigned DefWbW    = 2;
  localparam int unsigned DefCntW   = 16;

  // Control bundle is {regDest, aluSrc, aluOp, memControl, wbControl}.
  function automatic int unsigned ctrl_width(input int unsigned aluop_w,
                                             input int unsigned mem_w,
                                             input int unsigned wb_w);
    return 1 + aluop_w + 1 + mem_w + wb_w;
  endfunction

  localparam int unsigned DefCtrlW = ctrl_width(DefAluOpW, DefMemW, DefWbW);

endpackage

// File: rtl/id_ex_entry.sv
// One payload register of the ID/EX stage: load-enabled, cleared by async reset.
module id_ex_entry #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with a two-entry (main + skid) valid/ready buffer,
// flush, bubble-gated control outputs and a saturating stall counter.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned REG_W   = DefRegW,
  parameter int unsigned ALUOP_W = DefAluOpW,
  parameter int unsigned MEM_W   = DefMemW,
  parameter int unsigned WB_W    = DefWbW,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               inValid,
  output logic               inReady,
  input  logic               regDestIn,
  input  logic               aluSrcIn,
  input  logic [ALUOP_W-1:0] aluOpIn,
  input  logic [MEM_W-1:0]   memControlIn,
  input  logic [WB_W-1:0]    wbControlIn,
  input  logic [DATA_W-1:0]  readData1In,
  input  logic [DATA_W-1:0]  readData2In,
  input  logic [DATA_W-1:0]  signExtendIn,
  input  logic [DATA_W-1:0]  ifIdIn,
  input  logic [REG_W-1:0]   rdIn,
  input  logic [REG_W-1:0]   rtIn,
  input  logic [REG_W-1:0]   rsIn,
  output logic               outValid,
  input  logic               outReady,
  output logic               regDest,
  output logic               aluSrc,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [MEM_W-1:0]   memControl,
  output logic [WB_W-1:0]    wbControl,
  output logic [DATA_W-1:0]  readData1,
  output logic [DATA_W-1:0]  readData2,
  output logic [DATA_W-1:0]  signExtend,
  output logic [DATA_W-1:0]  ifId,
  output logic [REG_W-1:0]   rd,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   rs,
  output logic [CNT_W-1:0]   stallCount
);

  localparam int unsigned CtrlW = ctrl_width(ALUOP_W, MEM_W, WB_W);
  localparam int unsigned PayW  = CtrlW + 4 * DATA_W + 3 * REG_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic            m_valid_q, m_valid_d;
  logic            s_valid_q, s_valid_d;
  logic            m_load, s_load;
  logic            acc, deq;
  logic [PayW-1:0] in_pay, m_src, m_pay, s_pay;
  logic [CtrlW-1:0] m_ctrl;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_pay = {regDestIn, aluSrcIn, aluOpIn, memControlIn, wbControlIn,
                   readData1In, readData2In, signExtendIn, ifIdIn, rdIn, rtIn, rsIn};

  assign inReady = !s_valid_q && !flush;
  assign acc     = inValid && inReady;
  assign deq     = m_valid_q && outReady;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_load    = 1'b0;
    s_load    = 1'b0;
    m_src     = s_valid_q ? s_pay : in_pay;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || deq) begin
      // Skid drains first so order is preserved; acc is 0 whenever skid is full.
      m_valid_d = s_valid_q || acc;
      m_load    = s_valid_q || acc;
      s_valid_d = 1'b0;
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_load    = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (m_valid_q && !outReady && stall_q != CntMax) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      stall_q   <= stall_d;
    end
  end

  id_ex_entry #(
    .WIDTH(PayW)
  ) u_main (
    .clock(clock),
    .reset(reset),
    .load (m_load),
    .d    (m_src),
    .q    (m_pay)
  );

  id_ex_entry #(
    .WIDTH(PayW)
  ) u_skid (
    .clock(clock),
    .reset(reset),
    .load (s_load),
    .d    (in_pay),
    .q    (s_pay)
  );

  assign {m_ctrl, readData1, readData2, signExtend, ifId, rd, rt, rs} = m_pay;

  // Bubbles must never write memory or the register file.
  assign {regDest, aluSrc, aluOp, memControl, wbControl} = m_valid_q ? m_ctrl : '0;

  assign outValid   = m_valid_q;
  assign stallCount = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for flow/flush behaviour plus
// hand-written async-reset and stall-counter sequences.
module tb_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic        regDestIn, aluSrcIn;
  logic [1:0]  aluOpIn;
  logic [2:0]  memControlIn;
  logic [1:0]  wbControlIn;
  logic [31:0] readData1In, readData2In, signExtendIn, ifIdIn;
  logic [4:0]  rdIn, rtIn, rsIn;
  logic        outValid, outReady;
  logic        regDest, aluSrc;
  logic [1:0]  aluOp;
  logic [2:0]  memControl;
  logic [1:0]  wbControl;
  logic [31:0] readData1, readData2, signExtend, ifId;
  logic [4:0]  rd, rt, rs;
  logic [15:0] stallCount;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  id_ex_stage dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .inValid     (inValid),
    .inReady     (inReady),
    .regDestIn   (regDestIn),
    .aluSrcIn    (aluSrcIn),
    .aluOpIn     (aluOpIn),
    .memControlIn(memControlIn),
    .wbControlIn (wbControlIn),
    .readData1In (readData1In),
    .readData2In (readData2In),
    .signExtendIn(signExtendIn),
    .ifIdIn      (ifIdIn),
    .rdIn        (rdIn),
    .rtIn        (rtIn),
    .rsIn        (rsIn),
    .outValid    (outValid),
    .outReady    (outReady),
    .regDest     (regDest),
    .aluSrc      (aluSrc),
    .aluOp       (aluOp),
    .memControl  (memControl),
    .wbControl   (wbControl),
    .readData1   (readData1),
    .readData2   (readData2),
    .signExtend  (signExtend),
    .ifId        (ifId),
    .rd          (rd),
    .rt          (rt),
    .rs          (rs),
    .stallCount  (stallCount)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic       ordy;
    logic [4:0] rd_in;
    logic [1:0] wb_in;
    logic       e_ov;
    logic       e_ir;
    logic       chk_rd;
    logic [4:0] e_rd;
    logic [1:0] e_wb;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every payload field is derived from rd/wb so entries are distinguishable.
  task automatic drive(input logic fl, input logic iv, input logic ordy,
                       input logic [4:0] r, input logic [1:0] wb);
    flush        = fl;
    inValid      = iv;
    outReady     = ordy;
    rdIn         = r;
    rtIn         = r + 5'd1;
    rsIn         = r + 5'd2;
    wbControlIn  = wb;
    memControlIn = {1'b1, wb};
    regDestIn    = 1'b1;
    aluSrcIn     = 1'b1;
    aluOpIn      = 2'b11;
    readData1In  = 32'(r) * 32'h0101_0101;
    readData2In  = 32'(r) * 32'h0000_0101;
    signExtendIn = 32'(r) * 32'h0001_0001;
    ifIdIn       = 32'(r) * 32'd3;
  endtask

  initial begin
    //            fl iv or rd  wb   ov ir chk erd ewb
    vecs[0]  = '{0, 1, 1, 7,  1,   0, 1, 1,  0,  0};
    vecs[1]  = '{0, 1, 1, 8,  2,   1, 1, 1,  7,  1};
    vecs[2]  = '{0, 1, 1, 9,  3,   1, 1, 1,  8,  2};
    vecs[3]  = '{0, 0, 1, 0,  0,   1, 1, 1,  9,  3};
    vecs[4]  = '{0, 0, 0, 0,  0,   0, 1, 0,  0,  0};
    vecs[5]  = '{0, 1, 0, 10, 1,   0, 1, 0,  0,  0};
    vecs[6]  = '{0, 1, 0, 11, 2,   1, 1, 1,  10, 1};
    vecs[7]  = '{0, 1, 0, 12, 3,   1, 0, 1,  10, 1};
    vecs[8]  = '{0, 1, 1, 12, 3,   1, 0, 1,  10, 1};
    vecs[9]  = '{0, 1, 1, 12, 3,   1, 1, 1,  11, 2};
    vecs[10] = '{0, 0, 1, 0,  0,   1, 1, 1,  12, 3};
    vecs[11] = '{0, 0, 1, 0,  0,   0, 1, 0,  0,  0};
    vecs[12] = '{0, 1, 0, 20, 1,   0, 1, 0,  0,  0};
    vecs[13] = '{0, 1, 0, 21, 2,   1, 1, 1,  20, 1};
    vecs[14] = '{1, 1, 0, 22, 3,   1, 0, 1,  20, 1};
    vecs[15] = '{0, 0, 1, 0,  0,   0, 1, 0,  0,  0};
    vecs[16] = '{0, 0, 1, 0,  0,   0, 1, 0,  0,  0};
    vecs[17] = '{0, 1, 1, 30, 1,   0, 1, 0,  0,  0};
    vecs[18] = '{1, 1, 1, 31, 2,   1, 0, 1,  30, 1};
    vecs[19] = '{0, 0, 1, 0,  0,   0, 1, 0,  0,  0};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    #3;
    check("reset outValid", 64'(outValid), 64'd0);
    check("reset inReady", 64'(inReady), 64'd1);
    check("reset rd", 64'(rd), 64'd0);
    check("reset readData1", 64'(readData1), 64'd0);
    check("reset wbControl", 64'(wbControl), 64'd0);
    check("reset stallCount", 64'(stallCount), 64'd0);
    #9 reset = 1'b0;

    @(posedge clock);
    #1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ordy, vecs[i].rd_in, vecs[i].wb_in);
      @(negedge clock);
      check($sformatf("row%0d outValid", i), 64'(outValid), 64'(vecs[i].e_ov));
      check($sformatf("row%0d inReady", i), 64'(inReady), 64'(vecs[i].e_ir));
      check($sformatf("row%0d exCtrl", i), 64'({regDest, aluSrc, aluOp}),
            vecs[i].e_ov ? 64'hF : 64'h0);
      check($sformatf("row%0d wbControl", i), 64'(wbControl), 64'(vecs[i].e_wb));
      check($sformatf("row%0d memControl", i), 64'(memControl),
            vecs[i].e_ov ? 64'({1'b1, vecs[i].e_wb}) : 64'h0);
      if (vecs[i].chk_rd) begin
        check($sformatf("row%0d rd", i), 64'(rd), 64'(vecs[i].e_rd));
        check($sformatf("row%0d readData1", i), 64'(readData1),
              64'(32'(vecs[i].e_rd) * 32'h0101_0101));
        check($sformatf("row%0d ifId", i), 64'(ifId), 64'(32'(vecs[i].e_rd) * 32'd3));
      end
      @(posedge clock);
      #1;
    end

    // Async reset between edges with both entries full.
    drive(0, 1, 0, 5'd14, 2'd1);
    @(posedge clock);
    #1 drive(0, 1, 0, 5'd15, 2'd2);
    @(posedge clock);
    #1 drive(0, 0, 0, 0, 0);
    check("full outValid", 64'(outValid), 64'd1);
    check("full inReady", 64'(inReady), 64'd0);
    #1 reset = 1'b1;
    #1;
    check("areset outValid", 64'(outValid), 64'd0);
    check("areset inReady", 64'(inReady), 64'd1);
    check("areset rd", 64'(rd), 64'd0);
    check("areset stallCount", 64'(stallCount), 64'd0);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    check("post-reset outValid", 64'(outValid), 64'd0);
    check("post-reset inReady", 64'(inReady), 64'd1);

    // Stall counter: one entry held with outReady low.
    drive(0, 1, 0, 5'd25, 2'd1);
    @(posedge clock);
    #1 drive(0, 0, 0, 0, 0);
    check("stall outValid", 64'(outValid), 64'd1);
    check("stall start", 64'(stallCount), 64'd0);
    repeat (100) @(posedge clock);
    #1 check("stall 100", 64'(stallCount), 64'd100);
    repeat (69900) @(posedge clock);
    #1 check("stall saturated", 64'(stallCount), 64'd65535);
    check("stall entry held", 64'(rd), 64'd25);
    repeat (20) @(posedge clock);
    #1 check("stall stays", 64'(stallCount), 64'd65535);
    drive(1, 0, 0, 0, 0);
    @(posedge clock);
    #1 drive(0, 0, 1, 0, 0);
    check("flush outValid", 64'(outValid), 64'd0);
    check("flush keeps stallCount", 64'(stallCount), 64'd65535);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
